// File: rtl/multiplication.sv
// Sequential shift-add multiplier: product = a*b, one multiplier bit per clock.
// Define MUL_REM_ADD_EN to seed the accumulator with r, giving product = a*b + r.
module multiplication #(
  parameter  int SIZE   = 4,
  localparam int SIZE_2 = 2 * SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic [SIZE-1:0]   r,
  output logic              busy,
  output logic              done,
  output logic [SIZE_2-1:0] product
);

  localparam int CW = $clog2(SIZE) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SIZE_2-1:0] acc_q, acc_d;
  logic [SIZE_2-1:0] mcand_q, mcand_d;
  logic [SIZE-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SIZE_2-1:0] product_q, product_d;
  logic              done_q, done_d;
  logic [SIZE_2-1:0] acc_init;

`ifdef MUL_REM_ADD_EN
  assign acc_init = {{SIZE{1'b0}}, r};
`else
  // r stays on the port for drop-in compatibility but feeds nothing
  logic unused_r;
  assign unused_r = ^r;
  assign acc_init = '0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{SIZE{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          acc_d    = acc_init;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(SIZE - 1)) state_d = DONE;
      end
      DONE: begin
        product_d = acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == CALC) || (state_q == DONE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for multiplication (SIZE=4): vector table plus handshake,
// reset and back-to-back corner sequences. Honours MUL_REM_ADD_EN if defined.
module tb_multiplication;

  localparam int SIZE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [SIZE-1:0]  a = '0, b = '0, r = '0;
  logic             busy, done;
  logic [2*SIZE-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  multiplication #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .r(r),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b, r;
    int         exp_plain;
    int         exp_add;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int plain, input int add);
`ifdef MUL_REM_ADD_EN
    return add;
`else
    return plain;
`endif
  endfunction

  // start pulse at E0, operands scrambled after E0, done/product checked at E0+5
  task automatic run_op(input string name, input logic [3:0] va, vb, vr, input int exp);
    @(negedge clk);
    a = va; b = vb; r = vr; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb; r = ~vr;
    check({name, ".busy_e0"}, int'(busy), 1);
    for (int i = 1; i <= SIZE; i++) begin
      tick();
      check({name, ".done_early"}, int'(done), 0);
    end
    tick();
    check({name, ".done"}, int'(done), 1);
    check({name, ".product"}, int'(product), exp);
    check({name, ".busy_end"}, int'(busy), 0);
    tick();
    check({name, ".done_pulse"}, int'(done), 0);
    check({name, ".hold"}, int'(product), exp);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'd13, 4'd11, 4'd0,  143, 143};
    vecs[1] = '{4'd3,  4'd4,  4'd2,  12,  14};
    vecs[2] = '{4'd15, 4'd15, 4'd15, 225, 240};
    vecs[3] = '{4'd0,  4'd9,  4'd0,  0,   0};
    vecs[4] = '{4'd9,  4'd0,  4'd0,  0,   0};
    vecs[5] = '{4'd0,  4'd9,  4'd5,  0,   5};
    vecs[6] = '{4'd1,  4'd1,  4'd1,  1,   2};
    vecs[7] = '{4'd15, 4'd1,  4'd3,  15,  18};
    vecs[8] = '{4'd2,  4'd8,  4'd7,  16,  23};

    #12;
    check("rst.done", int'(done), 0);
    check("rst.product", int'(product), 0);
    check("rst.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle.busy", int'(busy), 0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r,
             pick(vecs[i].exp_plain, vecs[i].exp_add));

    // start pulse while busy must be ignored
    @(negedge clk);
    a = 4'd13; b = 4'd11; r = 4'd0; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick();                       // E0+1
    @(negedge clk);
    a = 4'd1; b = 4'd1; r = 4'd1; start = 1'b1;
    tick();                       // E0+2
    start = 1'b0;
    check("ign.busy", int'(busy), 1);
    tick(); tick();               // E0+4
    check("ign.done_early", int'(done), 0);
    tick();                       // E0+5
    check("ign.done", int'(done), 1);
    check("ign.product", int'(product), 143);
    tick();                       // E0+6
    check("ign.done_pulse", int'(done), 0);
    check("ign.busy_after", int'(busy), 0);

    // async reset mid-operation, then a clean op
    @(negedge clk);
    a = 4'd5; b = 4'd5; r = 4'd0; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick(); tick(); tick();       // E0+3
    rst_n = 1'b0;
    #1;
    check("arst.done", int'(done), 0);
    check("arst.product", int'(product), 0);
    check("arst.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 4'd7, 4'd6, 4'd0, 42);

    // start held high: back-to-back ops, operands sampled only at each E0
    @(negedge clk);
    a = 4'd5; b = 4'd6; r = 4'd1; start = 1'b1;
    tick();                       // E0
    a = 4'd2; b = 4'd3; r = 4'd4;
    for (int i = 1; i <= SIZE; i++) tick();
    tick();                       // E0+5
    check("b2b.done1", int'(done), 1);
    check("b2b.prod1", int'(product), pick(30, 31));
    tick();                       // E0+6: second op sampled
    check("b2b.done_gap", int'(done), 0);
    check("b2b.busy2", int'(busy), 1);
    start = 1'b0;
    for (int i = 1; i <= SIZE; i++) tick();
    check("b2b.done_early2", int'(done), 0);
    tick();                       // E0+11
    check("b2b.done2", int'(done), 1);
    check("b2b.prod2", int'(product), pick(6, 10));
    tick();
    check("b2b.idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
